// File: rtl/framebuffer_loader.sv
// UART byte-stream loader: parses CMD/ADDR/LEN/DATA packets into framebuffer writes.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHECK state).
module framebuffer_loader #(
  parameter logic [7:0] CMD_LOAD       = 8'h4C,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  ram_data,
  output logic [11:0] ram_addr,
  output logic        ram_wr,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK
  } state_t;
  logic [7:0]  r_xor;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA
  } state_t;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [23:0] r_tmo;
  logic [11:0] r_ptr;
  logic [11:0] r_cnt;
  logic        w_expire;
  logic        w_last;
  logic        w_wr;
  logic        w_done;
  logic        w_err;

  // An arriving byte always beats an expiring counter.
  assign w_expire = (r_state != S_IDLE) && !rx_valid && (r_tmo == TMO_LAST);
  assign w_last   = (r_cnt == 12'd0);
  assign busy     = (r_state != S_IDLE);

  // State register plus packet-field registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tmo   <= 24'd0;
      r_ptr   <= 12'd0;
      r_cnt   <= 12'd0;
`ifdef LOADER_CHECKSUM_EN
      r_xor   <= 8'd0;
`endif
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) || rx_valid || w_expire)
        r_tmo <= 24'd0;
      else
        r_tmo <= r_tmo + 24'd1;
      if (rx_valid) begin
        case (r_state)
          S_ADDR_HI: r_ptr[11:8] <= rx_data[3:0];
          S_ADDR_LO: r_ptr[7:0]  <= rx_data;
          S_LEN_HI:  r_cnt[11:8] <= rx_data[3:0];
          S_LEN_LO: begin
            r_cnt[7:0] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
            r_xor      <= 8'd0;
`endif
          end
          S_DATA: begin
            r_ptr <= r_ptr + 12'd1;
            r_cnt <= r_cnt - 12'd1;
`ifdef LOADER_CHECKSUM_EN
            r_xor <= r_xor ^ rx_data;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (w_expire) begin
      w_next = S_IDLE;
    end else if (rx_valid) begin
      case (r_state)
        S_IDLE:    if (rx_data == CMD_LOAD) w_next = S_ADDR_HI;
        S_ADDR_HI: w_next = S_ADDR_LO;
        S_ADDR_LO: w_next = S_LEN_HI;
        S_LEN_HI:  w_next = (rx_data[7:4] != 4'h0) ? S_IDLE : S_LEN_LO;
        S_LEN_LO:  w_next = S_DATA;
`ifdef LOADER_CHECKSUM_EN
        S_DATA:    if (w_last) w_next = S_CHECK;
        S_CHECK:   w_next = S_IDLE;
`else
        S_DATA:    if (w_last) w_next = S_IDLE;
`endif
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Output decode, registered below for single-cycle write latency
  always_comb begin
    w_wr   = 1'b0;
    w_done = 1'b0;
    w_err  = w_expire;
    if (rx_valid) begin
      case (r_state)
        S_LEN_HI: w_err = (rx_data[7:4] != 4'h0);
        S_DATA: begin
          w_wr = 1'b1;
`ifndef LOADER_CHECKSUM_EN
          w_done = w_last;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          w_done = (rx_data == r_xor);
          w_err  = (rx_data != r_xor);
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_wr   <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      ram_data <= 8'd0;
      ram_addr <= 12'd0;
    end else begin
      ram_wr <= w_wr;
      done   <= w_done;
      error  <= w_err;
      if (w_wr) begin
        ram_data <= rx_data;
        ram_addr <= r_ptr;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_loader.sv
// Randomized bench for framebuffer_loader with a packet-level reference model.
module tb_framebuffer_loader;

  localparam logic [7:0] CMD = 8'h4C;
  localparam int         TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [7:0]  ram_data;
  logic [11:0] ram_addr;
  logic        ram_wr, busy, done, error;

  framebuffer_loader #(.CMD_LOAD(CMD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the packet is just the list of bytes accepted since CMD.
  logic [7:0]  pkt[$];
  int          idle_cnt = 0;
  logic        m_wr = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [7:0]  m_data = 8'd0;
  logic [11:0] m_addr = 12'd0;

  task automatic model_step(input logic rs, input logic v, input logic [7:0] d);
    int i, len, base;
    logic [7:0] x;
    m_wr = 1'b0; m_done = 1'b0; m_err = 1'b0;
    if (rs) begin
      pkt.delete(); idle_cnt = 0; m_data = 8'd0; m_addr = 12'd0;
    end else if (v) begin
      idle_cnt = 0;
      if (pkt.size() == 0) begin
        if (d == CMD) pkt.push_back(d);
      end else begin
        pkt.push_back(d);
        i = pkt.size();
        if (i == 4 && d[7:4] != 4'h0) begin
          m_err = 1'b1; pkt.delete();
        end else if (i >= 6) begin
          len  = int'({pkt[3][3:0], pkt[4]});
          base = int'({pkt[1][3:0], pkt[2]});
          if (i <= 6 + len) begin
            m_wr = 1'b1; m_data = d; m_addr = 12'((base + i - 6) % 4096);
`ifndef LOADER_CHECKSUM_EN
            if (i == 6 + len) begin m_done = 1'b1; pkt.delete(); end
`endif
          end else begin
            x = 8'd0;
            for (int k = 5; k < i - 1; k++) x ^= pkt[k];
            if (d == x) m_done = 1'b1; else m_err = 1'b1;
            pkt.delete();
          end
        end
      end
    end else if (pkt.size() > 0) begin
      idle_cnt++;
      if (idle_cnt == TMO) begin m_err = 1'b1; pkt.delete(); idle_cnt = 0; end
    end
  endtask

  // Per-cycle compare plus logs used by the literal directed checks
  logic [11:0] la[$];
  logic [7:0]  ld[$];
  logic        lf[$];
  int done_cnt = 0, err_cnt = 0, cyc = 0, acc_cyc = -1, err_cyc = -1;
  bit started = 0;

  always @(posedge clk) begin
    logic s_rs, s_v;
    logic [7:0] s_d;
    s_rs = reset; s_v = rx_valid; s_d = rx_data;
    cyc++;
    if (s_v && !s_rs) acc_cyc = cyc;
    if (s_rs) started = 1;
    model_step(s_rs, s_v, s_d);
    #1;
    if (started) begin
      chk("ram_wr", 32'(ram_wr), 32'(m_wr));
      chk("done", 32'(done), 32'(m_done));
      chk("error", 32'(error), 32'(m_err));
      chk("busy", 32'(busy), 32'(pkt.size() > 0));
      chk("ram_data", 32'(ram_data), 32'(m_data));
      chk("ram_addr", 32'(ram_addr), 32'(m_addr));
      if (ram_wr === 1'b1) begin la.push_back(ram_addr); ld.push_back(ram_data); lf.push_back(done); end
      if (done === 1'b1) done_cnt++;
      if (error === 1'b1) begin err_cnt++; err_cyc = cyc; end
    end
  end

  // Drivers assume they are called at a falling edge.
  task automatic send(input logic [7:0] b, input int gap);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[k]) send(q[k], 0);
  endtask

  task automatic clr_logs();
    la.delete(); ld.delete(); lf.delete(); done_cnt = 0; err_cnt = 0; err_cyc = -1;
  endtask

  function automatic int pick_gap();
    int r;
    r = $urandom_range(0, 99);
    if (r < 60) return 0;
    if (r < 85) return 1;
    if (r < 93) return 3;
    if (r < 98) return 15;
    return 16;
  endfunction

  initial begin
    logic [7:0]  q[$];
    logic [11:0] lv;
    logic [7:0]  x, tmpb;
    int len, ncut;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_wr", 32'(ram_wr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_data", 32'(ram_data), 0);

    // Basic load of three bytes at 0x100
    clr_logs();
    q = '{8'h4C, 8'h01, 8'h00, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC};
`ifdef LOADER_CHECKSUM_EN
    q.push_back(8'hDD);
`endif
    send_q(q);
    repeat (2) @(negedge clk);
    chk("load_nwr", 32'(la.size()), 3);
    if (la.size() == 3) begin
      chk("load_a0", 32'(la[0]), 32'h100); chk("load_d0", 32'(ld[0]), 32'hAA);
      chk("load_a1", 32'(la[1]), 32'h101); chk("load_d1", 32'(ld[1]), 32'hBB);
      chk("load_a2", 32'(la[2]), 32'h102); chk("load_d2", 32'(ld[2]), 32'hCC);
`ifndef LOADER_CHECKSUM_EN
      chk("load_done_first", 32'(lf[0]), 0);
      chk("load_done_last", 32'(lf[2]), 1);
`endif
    end
    chk("load_done_cnt", 32'(done_cnt), 1);

    // Address wrap
    clr_logs();
    q = '{8'h4C, 8'h0F, 8'hFF, 8'h00, 8'h01, 8'h11, 8'h22};
`ifdef LOADER_CHECKSUM_EN
    q.push_back(8'h33);
`endif
    send_q(q);
    repeat (2) @(negedge clk);
    chk("wrap_nwr", 32'(la.size()), 2);
    if (la.size() == 2) begin
      chk("wrap_a0", 32'(la[0]), 32'hFFF); chk("wrap_d0", 32'(ld[0]), 32'h11);
      chk("wrap_a1", 32'(la[1]), 32'h000); chk("wrap_d1", 32'(ld[1]), 32'h22);
    end

    // Bad length, then a good packet
    clr_logs();
    q = '{8'h4C, 8'h00, 8'h00, 8'h10, 8'h00};
    send_q(q);
    repeat (2) @(negedge clk);
    chk("badlen_nwr", 32'(la.size()), 0);
    chk("badlen_err", 32'(err_cnt), 1);
    chk("badlen_busy", 32'(busy), 0);
    q = '{8'h4C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h5A};
`ifdef LOADER_CHECKSUM_EN
    q.push_back(8'h5A);
`endif
    send_q(q);
    repeat (2) @(negedge clk);
    chk("after_bad_nwr", 32'(la.size()), 1);
    if (la.size() == 1) chk("after_bad_a", 32'(la[0]), 32'h005);
    chk("after_bad_done", 32'(done_cnt), 1);

    // Timeout after 4C,00
    clr_logs();
    send(8'h4C, 0); send(8'h00, 0);
    for (int w = 0; w < 40 && err_cyc < 0; w++) @(negedge clk);
    chk("tmo_delay", 32'(err_cyc - acc_cyc), 32'(TMO));
    chk("tmo_busy", 32'(busy), 0);

    // Reset after two of four data bytes
    clr_logs();
    q = '{8'h4C, 8'h00, 8'h20, 8'h00, 8'h03, 8'hD1, 8'hD2};
    send_q(q);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_wr", 32'(ram_wr), 0);
    chk("mid_rst_addr", 32'(ram_addr), 0);
    chk("mid_rst_data", 32'(ram_data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    send(8'hD3, 0); send(8'hD4, 2);
    chk("mid_rst_nwr", 32'(la.size()), 2);
    chk("mid_rst_pulses", 32'(done_cnt + err_cnt), 0);

`ifdef LOADER_CHECKSUM_EN
    clr_logs();
    q = '{8'h4C, 8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
    send_q(q);
    repeat (2) @(negedge clk);
    chk("ck_ok_nwr", 32'(la.size()), 2);
    chk("ck_ok_done", 32'(done_cnt), 1);
    chk("ck_ok_err", 32'(err_cnt), 0);
    clr_logs();
    q = '{8'h4C, 8'h00, 8'h00, 8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    send_q(q);
    repeat (2) @(negedge clk);
    chk("ck_bad_nwr", 32'(la.size()), 2);
    chk("ck_bad_done", 32'(done_cnt), 0);
    chk("ck_bad_err", 32'(err_cnt), 1);
`endif

    // Random packets, garbage, bad lengths, truncations and near/over-timeout gaps
    for (int p = 0; p < 150; p++) begin
      if ($urandom_range(0, 3) == 0) begin
        tmpb = 8'($urandom);
        if (tmpb == CMD) tmpb = 8'h00;
        send(tmpb, pick_gap());
      end
      len = ($urandom_range(0, 99) < 80) ? $urandom_range(0, 15) : $urandom_range(16, 300);
      lv = 12'(len);
      q.delete();
      q.push_back(CMD);
      q.push_back(8'($urandom));
      q.push_back(8'($urandom));
      tmpb = {4'h0, lv[11:8]};
      if ($urandom_range(0, 14) == 0) tmpb[7:4] = 4'($urandom_range(1, 15));
      q.push_back(tmpb);
      q.push_back(lv[7:0]);
      x = 8'd0;
      for (int k = 0; k <= len; k++) begin
        tmpb = 8'($urandom);
        x ^= tmpb;
        q.push_back(tmpb);
      end
      if ($urandom_range(0, 4) == 0) x ^= 8'h01;
`ifdef LOADER_CHECKSUM_EN
      q.push_back(x);
`endif
      ncut = ($urandom_range(0, 9) == 0) ? $urandom_range(1, q.size() - 1) : q.size();
      for (int k = 0; k < ncut; k++) send(q[k], pick_gap());
      if (ncut != q.size()) repeat (TMO + 4) @(negedge clk);
    end
    repeat (TMO + 4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 300000", cyc);
    $fatal(1);
  end

endmodule

// File: doc/framebuffer_loader.md
FRAMEBUFFER_LOADER -- requirements
Module: framebuffer_loader

Interface
REQ-001 SHALL have parameter CMD_LOAD, default 8'h4C, command byte that opens a load packet.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum idle clocks between bytes inside a packet; legal range 2..2^24-1.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port rx_data, input, 8, received byte from the UART receiver.
REQ-006 SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port ram_data, output, 8, byte to the framebuffer 8-bit write port.
REQ-008 SHALL have port ram_addr, output, 12, byte address to the framebuffer write port.
REQ-009 SHALL have port ram_wr, output, 1, one-cycle write strobe.
REQ-010 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse on successful packet completion.
REQ-012 SHALL have port error, output, 1, one-cycle pulse on packet abort.

Function
REQ-013 SHALL implement states IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA, plus CHECK when the Configuration macro is defined.
REQ-014 SHALL ignore, in IDLE, any byte other than CMD_LOAD; CMD_LOAD moves the block to ADDR_HI.
REQ-015 SHALL take the start address from the low nibble of the ADDR_HI byte concatenated with the full ADDR_LO byte; the high nibble of ADDR_HI is ignored.
REQ-016 SHALL take a 12-bit length L from the low nibble of the LEN_HI byte concatenated with the full LEN_LO byte; the packet then carries L+1 data bytes (1..4096).
REQ-017 SHALL, if the high nibble of the LEN_HI byte is nonzero, pulse error on the next cycle and return to IDLE.
REQ-018 SHALL, for each data byte accepted in DATA, register ram_data, ram_addr and ram_wr=1 on the next clock edge; write latency is exactly 1 cycle.
REQ-019 SHALL increment the write address by 1 after each data byte, with modulo-4096 wrap (12'hFFF -> 12'h000).
REQ-020 SHALL, after the last data byte, pulse done in the same cycle as the final ram_wr and return to IDLE (no-checksum build).
REQ-021 SHALL hold ram_wr=0 in every cycle without a data write; ram_data and ram_addr keep their last values.
REQ-022 SHALL reset a timeout counter on every accepted byte; when the counter reaches TIMEOUT_CYCLES in any non-IDLE state, the block SHALL pulse error and return to IDLE.
REQ-023 SHALL let an rx_valid arriving in the cycle the counter would expire win: accept the byte and restart the counter.
REQ-024 SHALL NOT roll back writes already made when a packet aborts.
REQ-025 SHALL NOT run the timeout counter in IDLE.

Reset
REQ-026 SHALL, on reset, set state=IDLE and clear ram_wr, done, error, busy, ram_data, ram_addr, the byte counter and the timeout counter to 0 at that clock edge.
REQ-027 SHALL give reset priority over rx_valid; reset mid-packet discards the packet and issues no done or error pulse.

Configuration
REQ-028 SHALL use macro LOADER_CHECKSUM_EN to control the checksum feature.
REQ-029 SHALL, with LOADER_CHECKSUM_EN defined, keep an 8-bit running XOR of the data bytes; after the last data byte the block SHALL enter CHECK and expect one more byte; a match pulses done, a mismatch pulses error, both 1 cycle after that byte; then the block returns to IDLE.
REQ-030 SHALL, without LOADER_CHECKSUM_EN, omit CHECK and the XOR register entirely, with behaviour per REQ-020.

Verification
REQ-031 SHALL test the load: bytes 4C,01,00,00,02,AA,BB,CC -> ram_wr pulses at addresses 0x100,0x101,0x102 with data AA,BB,CC; done is coincident with the third write.
REQ-032 SHALL test wrap: 4C,0F,FF,00,01,11,22 -> writes 11@0xFFF and 22@0x000.
REQ-033 SHALL test a bad length: 4C,00,00,10,00 -> no ram_wr, error pulses once, busy drops, and a following valid packet loads normally.
REQ-034 SHALL test timeout: with TIMEOUT_CYCLES=16, send 4C,00 then silence -> error pulse exactly 16 cycles after the last byte; busy=0 afterwards.
REQ-035 SHALL test reset mid-packet: reset asserted after 2 of 4 data bytes -> all outputs 0 next edge, no done/error, and the remaining bytes are ignored unless they start with 4C.
REQ-036 SHALL test checksum with LOADER_CHECKSUM_EN: data 12,34 then checksum 26 -> done; checksum 27 -> error; both writes occur in both cases.
